// File: rtl/code_seq3_gen.sv
// 3-bit code sequencer for a 3-to-8 decoder: free-running stepping on a timer
// while in RUN, single manual steps while IDLE, with a wrap pulse on rollover.
module code_seq3_gen #(
   parameter logic [23:0] CNT_MAX = 24'd9_999_999
) (
   input  logic sys_clk,
   input  logic sys_rst_n,
   input  logic start,
   input  logic stop,
   input  logic dir,
   input  logic step,
   output logic in1,
   output logic in2,
   output logic in3,
   output logic busy,
   output logic wrap
);

   localparam int unsigned TW = 24;
   localparam int unsigned CW = 3;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   state_t          state_q, state_d;
   logic [TW-1:0]   timer_q, timer_d;
   logic [CW-1:0]   code_q, code_d;
   logic            busy_q, busy_d;
   logic            wrap_q, wrap_d;
   logic            adv;

   // State, timer, code and output flags
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state_q <= IDLE;
         timer_q <= '0;
         code_q  <= '0;
         busy_q  <= 1'b0;
         wrap_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         timer_q <= timer_d;
         code_q  <= code_d;
         busy_q  <= busy_d;
         wrap_q  <= wrap_d;
      end
   end

   // Next-state, timer and advance decision; stop has priority over start and terminal count
   always_comb begin
      state_d = state_q;
      timer_d = timer_q;
      code_d  = code_q;
      adv     = 1'b0;
      wrap_d  = 1'b0;

      case (state_q)
         IDLE: begin
            timer_d = '0;
            adv     = step;
            if (start && !stop) begin
               state_d = RUN;
            end
         end
         RUN: begin
            if (stop) begin
               state_d = IDLE;
               timer_d = '0;
            end else if (timer_q == CNT_MAX) begin
               timer_d = '0;
               adv     = 1'b1;
            end else begin
               timer_d = timer_q + TW'(1);
            end
         end
         default: begin
            state_d = IDLE;
            timer_d = '0;
         end
      endcase

      if (adv) begin
         code_d = dir ? code_q + CW'(1) : code_q - CW'(1);
         wrap_d = dir ? (code_q == CW'(7)) : (code_q == CW'(0));
      end

      busy_d = (state_d == RUN);
   end

   assign in1  = code_q[2];
   assign in2  = code_q[1];
   assign in3  = code_q[0];
   assign busy = busy_q;
   assign wrap = wrap_q;

endmodule

// File: tb/tb_code_seq3_gen.sv
// Scoreboard bench for code_seq3_gen with a 5-clock step interval: a cycle
// model pushes expected outputs per driven cycle, popped after each edge.
module tb_code_seq3_gen;

   localparam int unsigned CMAX = 4;

   logic clk = 1'b0;
   logic sys_rst_n;
   logic start, stop, dir, step;
   logic in1, in2, in3, busy, wrap;

   typedef struct packed {
      logic [2:0] code;
      logic       busy;
      logic       wrap;
   } exp_t;

   exp_t exp_q[$];

   int n_checks = 0;
   int n_fail   = 0;

   // reference model state
   logic       m_run;
   int         m_timer;
   logic [2:0] m_code;

   code_seq3_gen #(.CNT_MAX(24'(CMAX))) dut (
      .sys_clk  (clk),
      .sys_rst_n(sys_rst_n),
      .start    (start),
      .stop     (stop),
      .dir      (dir),
      .step     (step),
      .in1      (in1),
      .in2      (in2),
      .in3      (in3),
      .busy     (busy),
      .wrap     (wrap)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [2:0] dut_code();
      return {in1, in2, in3};
   endfunction

   task automatic model_reset();
      m_run   = 1'b0;
      m_timer = 0;
      m_code  = 3'd0;
   endtask

   // One clock: drive inputs at negedge, predict, then compare after the edge
   task automatic cyc(input logic s, input logic p, input logic d, input logic st);
      exp_t e;
      logic adv;
      @(negedge clk);
      start = s; stop = p; dir = d; step = st;
      adv = 1'b0;
      if (!m_run) begin
         if (st) adv = 1'b1;
         if (s && !p) begin
            m_run   = 1'b1;
            m_timer = 0;
         end
      end else if (p) begin
         m_run   = 1'b0;
         m_timer = 0;
      end else if (m_timer == CMAX) begin
         m_timer = 0;
         adv     = 1'b1;
      end else begin
         m_timer++;
      end
      e.wrap = 1'b0;
      if (adv) begin
         if (d) begin
            e.wrap = (m_code == 3'd7);
            m_code = (m_code == 3'd7) ? 3'd0 : m_code + 3'd1;
         end else begin
            e.wrap = (m_code == 3'd0);
            m_code = (m_code == 3'd0) ? 3'd7 : m_code - 3'd1;
         end
      end
      e.code = m_code;
      e.busy = m_run;
      exp_q.push_back(e);
      @(posedge clk);
      #1;
      if (exp_q.size() == 0) begin
         check("scoreboard_empty", 32'(0), 32'(1));
      end else begin
         e = exp_q.pop_front();
         check("code", 32'(dut_code()), 32'(e.code));
         check("busy", 32'(busy), 32'(e.busy));
         check("wrap", 32'(wrap), 32'(e.wrap));
      end
   endtask

   task automatic idle_cycles(input int n, input logic d);
      for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, d, 1'b0);
   endtask

   initial begin
      start = 1'b0; stop = 1'b0; dir = 1'b1; step = 1'b0;
      sys_rst_n = 1'b0;
      model_reset();
      #3;
      check("reset_code", 32'(dut_code()), 32'(0));
      check("reset_busy", 32'(busy), 32'(0));
      check("reset_wrap", 32'(wrap), 32'(0));
      @(negedge clk);
      sys_rst_n = 1'b1;
      idle_cycles(2, 1'b1);

      // start, dir up: first advance 5 clocks after entry, second 10
      cyc(1'b1, 1'b0, 1'b1, 1'b0);
      check("run_busy", 32'(busy), 32'(1));
      idle_cycles(4, 1'b1);
      check("pre_step1", 32'(dut_code()), 32'(0));
      idle_cycles(1, 1'b1);
      check("step1_code", 32'(dut_code()), 32'(3'b001));
      idle_cycles(5, 1'b1);
      check("step2_code", 32'(dut_code()), 32'(3'b010));

      // start while running is ignored, dir flips mid-interval
      idle_cycles(2, 1'b1);
      cyc(1'b1, 1'b0, 1'b1, 1'b0);
      cyc(1'b0, 1'b0, 1'b1, 1'b1);
      idle_cycles(1, 1'b0);
      idle_cycles(6, 1'b1);

      // run up through the 7->0 wrap, then down through 0->7
      for (int i = 0; i < 60 && m_code != 3'd0; i++) idle_cycles(1, 1'b1);
      check("wrap_up_reached", 32'(dut_code()), 32'(0));
      for (int i = 0; i < 12; i++) idle_cycles(1, 1'b0);

      // stop coincident with terminal count: no advance
      for (int i = 0; i < 10 && m_timer != CMAX; i++) idle_cycles(1, 1'b1);
      begin
         logic [2:0] held;
         held = m_code;
         cyc(1'b0, 1'b1, 1'b1, 1'b0);
         check("stop_tc_code", 32'(dut_code()), 32'(held));
         check("stop_tc_busy", 32'(busy), 32'(0));
      end
      idle_cycles(7, 1'b1);

      // back to code 0 via manual steps, then three down steps: 7,6,5
      for (int i = 0; i < 8 && m_code != 3'd0; i++) cyc(1'b0, 1'b0, 1'b1, 1'b1);
      cyc(1'b0, 1'b0, 1'b0, 1'b1);
      check("idle_step_7", 32'(dut_code()), 32'(7));
      check("idle_step_wrap", 32'(wrap), 32'(1));
      cyc(1'b0, 1'b0, 1'b0, 1'b1);
      check("idle_step_6", 32'(dut_code()), 32'(6));
      cyc(1'b0, 1'b0, 1'b0, 1'b1);
      check("idle_step_5", 32'(dut_code()), 32'(5));
      check("idle_step_busy", 32'(busy), 32'(0));

      // start+stop together from IDLE stays idle
      cyc(1'b1, 1'b1, 1'b1, 1'b0);
      check("start_stop_busy", 32'(busy), 32'(0));
      idle_cycles(6, 1'b1);

      // step with start: enter RUN and advance; step in RUN ignored
      cyc(1'b1, 1'b0, 1'b1, 1'b1);
      check("step_start_code", 32'(dut_code()), 32'(6));
      cyc(1'b0, 1'b0, 1'b1, 1'b1);
      cyc(1'b0, 1'b0, 1'b1, 1'b1);

      // async reset mid-run at code 5
      for (int i = 0; i < 60 && m_code != 3'd5; i++) idle_cycles(1, 1'b0);
      check("reach_code5", 32'(dut_code()), 32'(5));
      @(negedge clk);
      #2;
      sys_rst_n = 1'b0;
      model_reset();
      #1;
      check("async_rst_code", 32'(dut_code()), 32'(0));
      check("async_rst_busy", 32'(busy), 32'(0));
      @(negedge clk);
      sys_rst_n = 1'b1;
      idle_cycles(12, 1'b1);

      // decoder sweep: one-hot from 00000001 to 10000000
      for (int k = 0; k < 8; k++) begin
         logic [7:0] onehot;
         onehot = 8'(1) << dut_code();
         check("decoder", 32'(onehot), 32'(8'(1) << k));
         cyc(1'b0, 1'b0, 1'b1, 1'b1);
      end

      check("scoreboard_drained", 32'(exp_q.size()), 32'(0));
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
